event_capture: RTL and testbench
================================

Name: event_capture

Overview:
Consumer end of the trigger path: takes the probe bus plus `trigger_hit` from `trigger_unit` and records a pre/post-trigger window of probe samples into a circular buffer. After capture it streams the window out, oldest first, over a valid/ready read port to the readout/host logic. It sits directly downstream of `trigger_unit` in the event monitor.

Parameters:
- `PROBE_W`, 8, probe bus width; must match `trigger_unit`.
- `DEPTH`, 16, buffer entries; power of two, at least 4.
- `CNT_W`, `$clog2(DEPTH)`, localparam; width of pointers and `post_count`.

Ports:
- `clk`, in, 1, single clock; all logic on rising edge.
- `rst`, in, 1, synchronous reset, active-high.
- `probe_data`, in, `PROBE_W`, same probe bus that feeds `trigger_unit`.
- `trigger_hit`, in, 1, registered hit from `trigger_unit`; 1 cycle behind `probe_data`.
- `arm`, in, 1, pulse; starts a capture when IDLE.
- `abort`, in, 1, pulse; returns to IDLE from any state and discards the capture.
- `post_count`, in, `CNT_W`, samples stored after the trigger sample; sampled at trigger.
- `rd_data`, out, `PROBE_W`, readout sample.
- `rd_valid`, out, 1, `rd_data` valid.
- `rd_ready`, in, 1, consumer accepts `rd_data`.
- `rd_last`, out, 1, marks the final sample of the window; qualified by `rd_valid`.
- `armed`, out, 1, high in state ARMED.
- `triggered`, out, 1, high in states POST and DONE.
- `trig_index`, out, `CNT_W`, readout position (0 = first word out) of the trigger sample; valid in DONE.

Behaviour:
- **Reset:** `rst` has top priority, in any state and mid-readout. It forces state IDLE and clears `wr_ptr`, `fill`, `remaining`, `rd_cnt`, `trig_index`, `armed`, `triggered`, `rd_valid`, `rd_last` and the internal probe delay register. `rd_data` is don't-care while `rd_valid` is 0. Buffer contents are not cleared.
- **Alignment:** `probe_data` is registered once internally (`probe_q`). `probe_q` is the value written to the buffer, so the entry stored in the `trigger_hit` cycle is exactly the sample that caused the hit.
- **States:** IDLE, ARMED, POST, DONE. `abort` is checked after `rst` and before all other inputs; it forces IDLE in the next cycle.
- **IDLE:** `arm` goes to ARMED and clears `wr_ptr`, `fill`. `trigger_hit` is ignored.
- **ARMED:**
  - Writes `probe_q` to `mem[wr_ptr]` every cycle.
  - `wr_ptr` increments and wraps modulo `DEPTH`.
  - `fill` saturates at `DEPTH`.
  - On `trigger_hit`, the current write is the trigger sample. Latch `remaining` = `post_count`.
  - If `post_count` = 0, go directly to DONE; otherwise go to POST.
- **POST:**
  - Writes every cycle and decrements `remaining`.
  - After the write with `remaining` = 1, go to DONE.
  - `trigger_hit` is ignored.
  - `post_count` larger than `DEPTH-1` is clamped to `DEPTH-1`.
- **Window:** `fill` saturates at `DEPTH` during POST too, so the window size is `fill` (1..`DEPTH`). When `fill` = `DEPTH`, the oldest pre-trigger samples are overwritten.
  - `start` = `wr_ptr - fill` (mod `DEPTH`).
  - `trig_index` = `fill - 1 - post_count_clamped`.
- **DONE:**
  - `rd_valid` = 1 from the first DONE cycle, so data is available 1 cycle after the last write.
  - `rd_data` = `mem[start + rd_cnt]`.
  - A handshake occurs when `rd_valid` && `rd_ready`; it increments `rd_cnt`.
  - `rd_last` = (`rd_cnt` == `fill - 1`).
  - A handshake with `rd_last` high returns to IDLE; `rd_valid` is 0 next cycle.
  - `rd_data`, `rd_last` hold stable while `rd_valid` && !`rd_ready`.
- **`arm` outside IDLE:** ignored.
- **`trigger_hit` and `arm` in the same IDLE cycle:** no capture, only arming.

Optional Feature:
- Macro: `EVENT_CAPTURE_TIMESTAMP_EN`.
- **Defined:**
  - Adds a 32-bit free-running cycle counter, cleared by `rst` and wrapping at 2^32.
  - Adds output `trig_ts` [31:0]: counter value latched in the `trigger_hit` cycle that triggered, held until the next trigger, reset to 0.
- **Undefined:** port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- **Package `event_monitor_pkg`:** the `capture_state_e` enum (IDLE, ARMED, POST, DONE) and a `CAP_TS_W` = 32 constant. It is shared with the trigger bench and host register map.
- **Sub-module `capture_ram`:** `DEPTH`×`PROBE_W` register array, 1 write port, 1 asynchronous read port. Everything else stays in `event_capture`.

Test Plan:
1. **Basic window.** Set `post_count`=3 and arm; ramp `probe_data` 0x01,0x02,... each cycle; `trigger_hit` on the cycle after `probe_data`=0x0A.
   - Expect 0x01..0x0D, `fill`=13 words, `trig_index`=9.
   - `rd_last` on 0x0D, then back to IDLE.
2. **Wrap.** Arm, run 40 ramp cycles, trigger on value 0x20 with `post_count`=4.
   - Expect exactly 16 words 0x15..0x24.
   - `trig_index`=11.
3. **Zero post.** `post_count`=0, trigger on the first ARMED cycle.
   - Expect 1 word with `rd_last`=1 and `trig_index`=0.
   - DONE is entered the next cycle.
4. **Backpressure.** Repeat scenario 1 with `rd_ready` toggling 1010... and a 5-cycle low stretch.
   - `rd_data`/`rd_last` are stable while stalled.
   - Same 13-word sequence, no drops or duplicates.
5. **Abort/reset.**
   - `abort` in POST gives `armed`=`triggered`=`rd_valid`=0 next cycle; a later `trigger_hit` is ignored.
   - `rst` mid-readout gives IDLE with all outputs at reset values.
6. **Ignored inputs.**
   - `trigger_hit` while IDLE or POST: no state change.
   - `arm` during DONE: readout is unaffected.
   - With `EVENT_CAPTURE_TIMESTAMP_EN`, `trig_ts` equals cycles since reset at the trigger cycle.

Source files
------------

// File: rtl/event_monitor_pkg.sv
// event_monitor_pkg: definitions shared by the event monitor blocks
// (capture engine, trigger bench and host register map).
//   capture_state_e : capture FSM state encoding
//   CAP_TS_W        : width of the capture timestamp counter
package event_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } capture_state_e;

  localparam int CAP_TS_W = 32;

endpackage : event_monitor_pkg

// File: rtl/capture_ram.sv
// capture_ram: DEPTH x PROBE_W sample store for event_capture.
// One synchronous write port and one asynchronous read port. Contents are
// not reset.
// Ports:
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
module capture_ram #(
  parameter int  PROBE_W = 8,
  parameter int  DEPTH   = 16,
  localparam int CNT_W   = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [CNT_W-1:0]   waddr_i,
  input  logic [PROBE_W-1:0] wdata_i,
  input  logic [CNT_W-1:0]   raddr_i,
  output logic [PROBE_W-1:0] rdata_o
);

  logic [PROBE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : capture_ram

// File: rtl/event_capture.sv
// event_capture: records a pre/post-trigger window of probe samples into a
// circular buffer and streams it out oldest-first over a valid/ready port.
//
// Optional feature macro: EVENT_CAPTURE_TIMESTAMP_EN
//   When defined, a free-running 32-bit cycle counter is added and its value
//   in the triggering cycle is presented on trig_ts.
//
// Ports:
//   clk         : clock, all logic on the rising edge
//   rst         : synchronous active-high reset
//   probe_data  : probe bus (same bus that feeds trigger_unit)
//   trigger_hit : registered hit from trigger_unit, one cycle behind probe_data
//   arm         : pulse, starts a capture from IDLE
//   abort       : pulse, returns to IDLE from any state, discards the capture
//   post_count  : samples stored after the trigger sample, sampled at trigger
//   rd_data     : readout sample
//   rd_valid    : rd_data valid
//   rd_ready    : consumer accepts rd_data
//   rd_last     : final sample of the window, qualified by rd_valid
//   armed       : high while waiting for a trigger
//   triggered   : high in POST and DONE
//   trig_index  : readout position of the trigger sample, valid in DONE
//   trig_ts     : (EVENT_CAPTURE_TIMESTAMP_EN only) cycle count at trigger
module event_capture
  import event_monitor_pkg::*;
#(
  parameter int  PROBE_W = 8,
  parameter int  DEPTH   = 16,
  localparam int CNT_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PROBE_W-1:0]  probe_data,
  input  logic                trigger_hit,
  input  logic                arm,
  input  logic                abort,
  input  logic [CNT_W-1:0]    post_count,
  output logic [PROBE_W-1:0]  rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_last,
  output logic                armed,
  output logic                triggered,
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
  output logic [CAP_TS_W-1:0] trig_ts,
`endif
  output logic [CNT_W-1:0]    trig_index
);

  // fill must represent DEPTH itself, so it is one bit wider than a pointer.
  localparam int                FILL_W   = CNT_W + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
    return (f == FILL_MAX) ? f : f + FILL_W'(1);
  endfunction

  // Trigger sample position within the window: everything after it is the
  // post-trigger tail, so it sits post samples before the newest entry.
  function automatic logic [CNT_W-1:0] calc_trig_index(input logic [FILL_W-1:0] f,
                                                       input logic [CNT_W-1:0]  post);
    return CNT_W'(f - FILL_W'(1) - FILL_W'(post));
  endfunction

  capture_state_e     state_q, state_d;
  logic [PROBE_W-1:0] probe_q;
  logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   post_q, post_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   trig_index_q, trig_index_d;

  logic               we;
  logic [CNT_W-1:0]   start_ptr;
  logic [CNT_W-1:0]   rd_addr;
  logic [CNT_W-1:0]   last_idx;
  logic [FILL_W-1:0]  fill_next;
  logic               trig_fire;
  logic               rd_hs;

  // post_count is CNT_W bits wide, so it can never exceed DEPTH-1 and the
  // clamp to DEPTH-1 is implicit in the port width.
  assign fill_next = fill_inc(fill_q);
  assign trig_fire = (state_q == ARMED) && trigger_hit && !abort;
  assign rd_hs     = rd_valid && rd_ready;

  // Oldest entry of the window; when fill == DEPTH the low bits are zero and
  // the oldest entry is the one about to be overwritten at wr_ptr.
  assign start_ptr = wr_ptr_q - fill_q[CNT_W-1:0];
  assign rd_addr   = start_ptr + rd_cnt_q;
  assign last_idx  = CNT_W'(fill_q - FILL_W'(1));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    remaining_d  = remaining_q;
    post_d       = post_q;
    rd_cnt_d     = rd_cnt_q;
    trig_index_d = trig_index_q;
    we           = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm) begin
            state_d  = ARMED;
            wr_ptr_d = '0;
            fill_d   = '0;
            rd_cnt_d = '0;
          end
        end
        ARMED: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + CNT_W'(1);
          fill_d   = fill_next;
          if (trigger_hit) begin
            remaining_d = post_count;
            post_d      = post_count;
            rd_cnt_d    = '0;
            if (post_count == '0) begin
              state_d      = DONE;
              trig_index_d = calc_trig_index(fill_next, post_count);
            end else begin
              state_d = POST;
            end
          end
        end
        POST: begin
          we          = 1'b1;
          wr_ptr_d    = wr_ptr_q + CNT_W'(1);
          fill_d      = fill_next;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d      = DONE;
            trig_index_d = calc_trig_index(fill_next, post_q);
          end
        end
        DONE: begin
          if (rd_hs) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (rd_last) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage boundary: probe alignment register and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      probe_q      <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      remaining_q  <= '0;
      post_q       <= '0;
      rd_cnt_q     <= '0;
      trig_index_q <= '0;
    end else begin
      state_q      <= state_d;
      probe_q      <= probe_data;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      remaining_q  <= remaining_d;
      post_q       <= post_d;
      rd_cnt_q     <= rd_cnt_d;
      trig_index_q <= trig_index_d;
    end
  end

  capture_ram #(
    .PROBE_W (PROBE_W),
    .DEPTH   (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (probe_q),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign armed      = (state_q == ARMED);
  assign triggered  = (state_q == POST) || (state_q == DONE);
  assign rd_valid   = (state_q == DONE);
  assign rd_last    = rd_valid && (rd_cnt_q == last_idx);
  assign trig_index = trig_index_q;

`ifdef EVENT_CAPTURE_TIMESTAMP_EN
  logic [CAP_TS_W-1:0] ts_cnt_q;
  logic [CAP_TS_W-1:0] trig_ts_q;

  // Stage boundary: free-running timestamp and trigger-time latch
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q  <= '0;
      trig_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + CAP_TS_W'(1);
      if (trig_fire) begin
        trig_ts_q <= ts_cnt_q;
      end
    end
  end

  assign trig_ts = trig_ts_q;
`else
  // Without timestamps the trigger-fire strobe has no consumer.
  logic unused_trig_fire;
  assign unused_trig_fire = trig_fire;
`endif

endmodule : event_capture

// File: tb/tb_event_capture.sv
module tb_event_capture;

  logic        clk;
  logic        rst;
  logic [7:0]  probe_data;
  logic        trigger_hit;
  logic        arm;
  logic        abort;
  logic [3:0]  post_count;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic        armed;
  logic        triggered;
  logic [3:0]  trig_index;
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
  logic [31:0] trig_ts;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] got [32];

  event_capture #(.PROBE_W(8), .DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .probe_data  (probe_data),
    .trigger_hit (trigger_hit),
    .arm         (arm),
    .abort       (abort),
    .post_count  (post_count),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_last     (rd_last),
    .armed       (armed),
    .triggered   (triggered),
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
    .trig_ts     (trig_ts),
`endif
    .trig_index  (trig_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arms with probe_data=0x01 in the arm cycle and ramps by one per cycle;
  // trigger_hit is raised in the cycle where the internal probe register
  // holds trig_val. Returns once the last post-trigger write has happened.
  task automatic capture(input logic [3:0] post, input logic [7:0] trig_val, input bit retrig);
    logic [7:0] v;
    post_count = post;
    probe_data = 8'h01;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    v = 8'h01;
    for (int i = 0; i < int'(trig_val) + int'(post); i++) begin
      probe_data  = v + 8'h01;
      trigger_hit = (v == trig_val) || (retrig && (v == trig_val + 8'h01));
      tick();
      v = v + 8'h01;
    end
    trigger_hit = 1'b0;
  endtask

  // Collects the readout into got[]; bp selects the ready pattern
  // (1010... with a 5-cycle low stretch).
  task automatic drain(input bit bp, output int cnt, output int last_pos,
                       output int last_cnt, output int unstable);
    logic [7:0] pd;
    logic       pl;
    bit         stalled;
    bit         fin;
    cnt = 0; last_pos = -1; last_cnt = 0; unstable = 0;
    stalled = 1'b0; pd = '0; pl = 1'b0; fin = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (bp) rd_ready = (c >= 4 && c < 9) ? 1'b0 : (c % 2 == 0);
      else    rd_ready = 1'b1;
      if (stalled && rd_valid && (rd_data !== pd || rd_last !== pl)) unstable++;
      stalled = rd_valid && !rd_ready;
      pd = rd_data;
      pl = rd_last;
      if (rd_valid && rd_ready) begin
        if (cnt < 32) got[cnt] = rd_data;
        if (rd_last) begin
          last_cnt++;
          if (last_pos < 0) last_pos = cnt;
          fin = 1'b1;
        end
        cnt++;
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (armed !== 1'b0) $display("FAIL reset_armed got=%b exp=0", armed); else n_pass++;
    n_checks++; if (triggered !== 1'b0) $display("FAIL reset_triggered got=%b exp=0", triggered); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else n_pass++;
    n_checks++; if (rd_last !== 1'b0) $display("FAIL reset_rd_last got=%b exp=0", rd_last); else n_pass++;
    n_checks++; if (trig_index !== 4'd0) $display("FAIL reset_trig_index got=%0d exp=0", trig_index); else n_pass++;
  endtask

  task automatic test_basic();
    int cnt, lp, lc, us;
    capture(4'd3, 8'h0A, 1'b0);
    n_checks++; if (rd_valid !== 1'b1) $display("FAIL basic_done_valid got=%b exp=1", rd_valid); else n_pass++;
    n_checks++; if (triggered !== 1'b1) $display("FAIL basic_triggered got=%b exp=1", triggered); else n_pass++;
    n_checks++; if (trig_index !== 4'd9) $display("FAIL basic_trig_index got=%0d exp=9", trig_index); else n_pass++;
    drain(1'b0, cnt, lp, lc, us);
    n_checks++; if (cnt != 13) $display("FAIL basic_count got=%0d exp=13", cnt); else n_pass++;
    for (int i = 0; i < 13 && i < cnt; i++) begin
      n_checks++;
      if (got[i] !== 8'(i + 1)) $display("FAIL basic_word%0d got=%h exp=%h", i, got[i], 8'(i + 1));
      else n_pass++;
    end
    n_checks++; if (lp != 12) $display("FAIL basic_last_pos got=%0d exp=12", lp); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0 || triggered !== 1'b0) $display("FAIL basic_idle_after got=%b%b exp=00", rd_valid, triggered); else n_pass++;
  endtask

  task automatic test_wrap();
    int cnt, lp, lc, us;
    capture(4'd4, 8'h20, 1'b0);
    n_checks++; if (trig_index !== 4'd11) $display("FAIL wrap_trig_index got=%0d exp=11", trig_index); else n_pass++;
    drain(1'b0, cnt, lp, lc, us);
    n_checks++; if (cnt != 16) $display("FAIL wrap_count got=%0d exp=16", cnt); else n_pass++;
    for (int i = 0; i < 16 && i < cnt; i++) begin
      n_checks++;
      if (got[i] !== 8'(8'h15 + i)) $display("FAIL wrap_word%0d got=%h exp=%h", i, got[i], 8'(8'h15 + i));
      else n_pass++;
    end
    n_checks++; if (lp != 15) $display("FAIL wrap_last_pos got=%0d exp=15", lp); else n_pass++;
  endtask

  task automatic test_zero_post();
    int cnt, lp, lc, us;
    capture(4'd0, 8'h01, 1'b0);
    n_checks++; if (rd_valid !== 1'b1) $display("FAIL zero_done_next got=%b exp=1", rd_valid); else n_pass++;
    n_checks++; if (rd_last !== 1'b1) $display("FAIL zero_rd_last got=%b exp=1", rd_last); else n_pass++;
    n_checks++; if (trig_index !== 4'd0) $display("FAIL zero_trig_index got=%0d exp=0", trig_index); else n_pass++;
    drain(1'b0, cnt, lp, lc, us);
    n_checks++; if (cnt != 1) $display("FAIL zero_count got=%0d exp=1", cnt); else n_pass++;
    n_checks++; if (got[0] !== 8'h01) $display("FAIL zero_word got=%h exp=01", got[0]); else n_pass++;
  endtask

  task automatic test_backpressure();
    int cnt, lp, lc, us;
    capture(4'd3, 8'h0A, 1'b0);
    drain(1'b1, cnt, lp, lc, us);
    n_checks++; if (cnt != 13) $display("FAIL bp_count got=%0d exp=13", cnt); else n_pass++;
    for (int i = 0; i < 13 && i < cnt; i++) begin
      n_checks++;
      if (got[i] !== 8'(i + 1)) $display("FAIL bp_word%0d got=%h exp=%h", i, got[i], 8'(i + 1));
      else n_pass++;
    end
    n_checks++; if (us != 0) $display("FAIL bp_stall_stable got=%0d exp=0", us); else n_pass++;
    n_checks++; if (lc != 1 || lp != 12) $display("FAIL bp_last got=%0d@%0d exp=1@12", lc, lp); else n_pass++;
  endtask

  task automatic test_abort_reset();
    // Abort while in POST: trigger at value 3 with a long tail.
    post_count = 4'd8;
    probe_data = 8'h01;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      probe_data  = 8'(i + 1);
      trigger_hit = (i == 3);
      tick();
    end
    trigger_hit = 1'b0;
    n_checks++; if (triggered !== 1'b1) $display("FAIL abort_in_post got=%b exp=1", triggered); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if ({armed, triggered, rd_valid} !== 3'b000) $display("FAIL abort_outputs got=%b exp=000", {armed, triggered, rd_valid}); else n_pass++;
    trigger_hit = 1'b1;
    tick();
    trigger_hit = 1'b0;
    tick();
    n_checks++; if ({armed, triggered, rd_valid} !== 3'b000) $display("FAIL abort_trig_ignored got=%b exp=000", {armed, triggered, rd_valid}); else n_pass++;
    // Reset in the middle of a readout.
    capture(4'd3, 8'h0A, 1'b0);
    rd_ready = 1'b1;
    tick();
    tick();
    rd_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({armed, triggered, rd_valid, rd_last} !== 4'b0000) $display("FAIL rst_mid_outputs got=%b exp=0000", {armed, triggered, rd_valid, rd_last}); else n_pass++;
    n_checks++; if (trig_index !== 4'd0) $display("FAIL rst_mid_trig_index got=%0d exp=0", trig_index); else n_pass++;
  endtask

  task automatic test_ignored();
    int cnt, lp, lc, us;
    // trigger_hit alone in IDLE
    trigger_hit = 1'b1;
    tick();
    trigger_hit = 1'b0;
    tick();
    n_checks++; if ({armed, triggered} !== 2'b00) $display("FAIL idle_trig got=%b exp=00", {armed, triggered}); else n_pass++;
    // arm and trigger_hit together in IDLE: only arms
    arm = 1'b1;
    trigger_hit = 1'b1;
    tick();
    arm = 1'b0;
    trigger_hit = 1'b0;
    n_checks++; if ({armed, triggered} !== 2'b10) $display("FAIL arm_with_trig got=%b exp=10", {armed, triggered}); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    // Second trigger_hit during POST, then arm during DONE
    capture(4'd3, 8'h0A, 1'b1);
    n_checks++; if (trig_index !== 4'd9) $display("FAIL retrig_trig_index got=%0d exp=9", trig_index); else n_pass++;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    n_checks++; if ({armed, rd_valid} !== 2'b01) $display("FAIL arm_in_done got=%b exp=01", {armed, rd_valid}); else n_pass++;
    drain(1'b0, cnt, lp, lc, us);
    n_checks++; if (cnt != 13) $display("FAIL retrig_count got=%0d exp=13", cnt); else n_pass++;
    n_checks++; if (got[0] !== 8'h01 || got[12 % 32] !== 8'h0D) $display("FAIL retrig_ends got=%h..%h exp=01..0d", got[0], got[12]); else n_pass++;
  endtask

`ifdef EVENT_CAPTURE_TIMESTAMP_EN
  task automatic test_timestamp();
    int cnt, lp, lc, us;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Arm cycle is cycle 0 after reset; trigger on value 5 lands on cycle 5.
    capture(4'd2, 8'h05, 1'b0);
    n_checks++; if (trig_ts !== 32'd5) $display("FAIL trig_ts got=%0d exp=5", trig_ts); else n_pass++;
    drain(1'b0, cnt, lp, lc, us);
  endtask
`endif

  initial begin
    rst = 1'b1; probe_data = '0; trigger_hit = 1'b0; arm = 1'b0;
    abort = 1'b0; post_count = '0; rd_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_post();
    test_backpressure();
    test_abort_reset();
    test_ignored();
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_event_capture
